// File: rtl/mem_fill_arbiter_if.sv
// Bus bundle between the I/D cache miss controllers, the fill arbiter and the unified memory.
// The arbiter connects through the slave modport; requesters and the memory use master.
interface mem_fill_arbiter_if #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = $clog2(WORDS_PER_BLOCK);

  // Requester side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              i_grant;
  logic              d_grant;
  logic              i_fill_we;
  logic              d_fill_we;
  logic [IDX_W-1:0]  fill_word;
  logic [WORD_W-1:0] fill_data;
  logic              i_done;
  logic              d_done;
  logic              busy;

  // Memory side
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_grant, d_grant, i_fill_we, d_fill_we, fill_word, fill_data,
           i_done, d_done, busy, mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_grant, d_grant, i_fill_we, d_fill_we, fill_word, fill_data,
           i_done, d_done, busy, mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbiter sharing one pipelined unified memory between the I-cache fill path and the
// D-cache fill / write-through path. Sequences WORDS_PER_BLOCK-word block fills and
// single-word write-throughs for one owner at a time.
// Optional build macro ARB_ROUND_ROBIN_EN: ties in IDLE go to the side not granted last;
// without it D always beats I.
module mem_fill_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_fill_arbiter_if.slave bus
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned OFF_W  = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [IDX_W-1:0]  r_issue_cnt;
  logic [IDX_W-1:0]  r_ret_cnt;
  logic              w_d_win;
  logic              w_i_win;
  logic              w_ret;
  logic              w_last_issue;
  logic              w_last_ret;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t            r_last_owner;

  // On a tie the side that was not granted last wins.
  assign w_d_win = bus.d_req & (~bus.i_req | (r_last_owner == OWN_I));
`else
  assign w_d_win = bus.d_req;
`endif
  assign w_i_win = bus.i_req & ~w_d_win;

  // Returns only count while a fill is outstanding; anything else is stale.
  assign w_ret        = bus.mem_rvalid & ((r_state == S_ISSUE) | (r_state == S_DRAIN));
  assign w_last_issue = (r_issue_cnt == LAST_IDX);
  assign w_last_ret   = w_ret & (r_ret_cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operation context: owner and request captured at grant, issue/return counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_I;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_d_win) begin
        r_owner <= OWN_D;
        r_addr  <= bus.d_addr;
        r_wdata <= bus.d_wdata;
      end else if (w_i_win) begin
        r_owner <= OWN_I;
        r_addr  <= bus.i_addr;
      end
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_issue_cnt <= r_issue_cnt + IDX_W'(1);
      end
      if (w_ret) begin
        r_ret_cnt <= r_ret_cnt + IDX_W'(1);
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the last winner; write-throughs count as D. Resets to D so I wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_D;
    end else if ((r_state == S_IDLE) && (w_d_win || w_i_win)) begin
      r_last_owner <= w_d_win ? OWN_D : OWN_I;
    end
  end
`endif

  // Next state and output decode from the current state, owner and memory returns.
  always_comb begin
    w_state_nxt    = r_state;
    bus.busy       = (r_state != S_IDLE);
    bus.i_grant    = (r_state != S_IDLE) && (r_owner == OWN_I);
    bus.d_grant    = (r_state != S_IDLE) && (r_owner == OWN_D);
    bus.i_fill_we  = 1'b0;
    bus.d_fill_we  = 1'b0;
    bus.fill_word  = '0;
    bus.fill_data  = '0;
    bus.i_done     = 1'b0;
    bus.d_done     = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    if (w_ret) begin
      bus.fill_word = r_ret_cnt;
      bus.fill_data = bus.mem_rdata;
      bus.i_fill_we = (r_owner == OWN_I);
      bus.d_fill_we = (r_owner == OWN_D);
    end

    case (r_state)
      S_IDLE: begin
        if (w_d_win) begin
          w_state_nxt = bus.d_wr ? S_WRITE : S_ISSUE;
        end else if (w_i_win) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WRITE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = r_addr;
        bus.mem_wdata  = r_wdata;
        bus.d_done     = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      S_ISSUE: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = {r_addr[ADDR_W-1:OFF_W], r_issue_cnt, 1'b0};
        if (w_last_issue) begin
          w_state_nxt = w_last_ret ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_ret) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.i_done  = (r_owner == OWN_I);
        bus.d_done  = (r_owner == OWN_D);
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end
endmodule
